// File: rtl/stack_draw_engine_if.sv
// Bundles the stack, font ROM, framebuffer and status signals of the
// stack-driven glyph renderer.
//   master : the draw engine (drives pop, font_addr, fb_*, busy, char_done,
//            chars_drawn)
//   slave  : the environment (stack, font ROM, framebuffer, control)
interface stack_draw_engine_if #(
   parameter int unsigned CHAR_ID_WIDTH = 8,
   parameter int unsigned X_WIDTH       = 9,
   parameter int unsigned Y_WIDTH       = 9
);
   logic                       enable;
   logic                       empty;
   logic                       pop;
   logic [CHAR_ID_WIDTH-1:0]   character_id_out;
   logic [X_WIDTH-1:0]         x_out;
   logic [Y_WIDTH-1:0]         y_out;
   logic [CHAR_ID_WIDTH+2:0]   font_addr;
   logic [7:0]                 font_data;
   logic                       fb_we;
   logic [X_WIDTH-1:0]         fb_x;
   logic [Y_WIDTH-1:0]         fb_y;
   logic                       fb_pixel;
   logic                       fb_ready;
   logic                       busy;
   logic                       char_done;
   logic [15:0]                chars_drawn;

   modport master (
      input  enable, empty, character_id_out, x_out, y_out, font_data, fb_ready,
      output pop, font_addr, fb_we, fb_x, fb_y, fb_pixel, busy, char_done, chars_drawn
   );

   modport slave (
      output enable, empty, character_id_out, x_out, y_out, font_data, fb_ready,
      input  pop, font_addr, fb_we, fb_x, fb_y, fb_pixel, busy, char_done, chars_drawn
   );
endinterface

// File: rtl/stack_draw_engine.sv
// Pops glyph entries (char id, x, y) from a stack, fetches each of the eight
// glyph rows from a synchronous font ROM and writes the 8x8 pixels to a
// framebuffer with clipping, optional transparency and fb_ready backpressure.
// Ports:
//   clock     : rising-edge clock
//   reset     : asynchronous, active-high reset
//   bus       : stack_draw_engine_if.master
//               enable/empty/pop/character_id_out/x_out/y_out : stack side
//               font_addr/font_data                           : font ROM
//               fb_we/fb_x/fb_y/fb_pixel/fb_ready             : framebuffer
//               busy/char_done/chars_drawn                    : status
module stack_draw_engine #(
   parameter int unsigned CHAR_ID_WIDTH = 8,
   parameter int unsigned X_WIDTH       = 9,
   parameter int unsigned Y_WIDTH       = 9,
   parameter int unsigned SCREEN_W      = 320,
   parameter int unsigned SCREEN_H      = 240,
   parameter bit          TRANSPARENT   = 1'b0
) (
   input  logic                clock,
   input  logic                reset,
   stack_draw_engine_if.master bus
);

   localparam int unsigned XPW = X_WIDTH + 1;
   localparam int unsigned YPW = Y_WIDTH + 1;
   localparam int unsigned AW  = CHAR_ID_WIDTH + 3;
   localparam logic [XPW-1:0] SCREEN_W_LIM = XPW'(SCREEN_W);
   localparam logic [YPW-1:0] SCREEN_H_LIM = YPW'(SCREEN_H);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_LATCH,
      S_ROM_REQ,
      S_ROM_WAIT,
      S_DRAW
   } state_t;

   state_t                   state_q, state_d;
   logic [CHAR_ID_WIDTH-1:0] char_q, char_d;
   logic [X_WIDTH-1:0]       x_q, x_d;
   logic [Y_WIDTH-1:0]       y_q, y_d;
   logic [2:0]               row_q, row_d;
   logic [2:0]               col_q, col_d;
   logic [7:0]               bits_q, bits_d;

   logic                     pop_q, pop_d;
   logic [AW-1:0]            font_addr_q, font_addr_d;
   logic                     fb_we_q, fb_we_d;
   logic [X_WIDTH-1:0]       fb_x_q, fb_x_d;
   logic [Y_WIDTH-1:0]       fb_y_q, fb_y_d;
   logic                     fb_pixel_q, fb_pixel_d;
   logic                     busy_q, busy_d;
   logic                     char_done_q, char_done_d;
   logic [15:0]              chars_drawn_q, chars_drawn_d;

   // Pixel that will be presented next: column 0 of a freshly fetched row,
   // or the column after the current one within the latched row.
   logic [7:0]               cand_bits;
   logic [2:0]               cand_col;
   logic [XPW-1:0]           cand_px;
   logic [YPW-1:0]           cand_py;
   logic                     cand_bit;
   logic                     cand_we;

   always_comb begin
      cand_bits = bits_q;
      cand_col  = col_q + 3'd1;
      if (state_q == S_ROM_WAIT) begin
         cand_bits = bus.font_data;
         cand_col  = 3'd0;
      end
      // One bit wider than the origin so a glyph near the edge never wraps.
      cand_px  = {1'b0, x_q} + XPW'(cand_col);
      cand_py  = {1'b0, y_q} + YPW'(row_q);
      cand_bit = cand_bits[3'd7 - cand_col];
      cand_we  = (cand_px < SCREEN_W_LIM) && (cand_py < SCREEN_H_LIM) &&
                 (!TRANSPARENT || cand_bit);
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d       = state_q;
      char_d        = char_q;
      x_d           = x_q;
      y_d           = y_q;
      row_d         = row_q;
      col_d         = col_q;
      bits_d        = bits_q;
      pop_d         = 1'b0;
      font_addr_d   = font_addr_q;
      fb_we_d       = 1'b0;
      fb_x_d        = fb_x_q;
      fb_y_d        = fb_y_q;
      fb_pixel_d    = fb_pixel_q;
      char_done_d   = 1'b0;
      chars_drawn_d = chars_drawn_q;

      case (state_q)
         S_IDLE: begin
            if (bus.enable && !bus.empty) begin
               state_d = S_POP;
               pop_d   = 1'b1;
            end
         end
         S_POP: begin
            state_d = S_LATCH;
         end
         S_LATCH: begin
            char_d      = bus.character_id_out;
            x_d         = bus.x_out;
            y_d         = bus.y_out;
            row_d       = 3'd0;
            font_addr_d = {bus.character_id_out, 3'd0};
            state_d     = S_ROM_REQ;
         end
         S_ROM_REQ: begin
            state_d = S_ROM_WAIT;
         end
         S_ROM_WAIT: begin
            bits_d     = bus.font_data;
            col_d      = 3'd0;
            fb_we_d    = cand_we;
            fb_x_d     = cand_px[X_WIDTH-1:0];
            fb_y_d     = cand_py[Y_WIDTH-1:0];
            fb_pixel_d = cand_bit;
            state_d    = S_DRAW;
         end
         S_DRAW: begin
            if (fb_we_q && !bus.fb_ready) begin
               // Write not yet accepted: hold column and all fb outputs.
               fb_we_d = 1'b1;
            end else if (col_q == 3'd7) begin
               if (row_q == 3'd7) begin
                  state_d       = S_IDLE;
                  char_done_d   = 1'b1;
                  chars_drawn_d = chars_drawn_q + 16'd1;
               end else begin
                  row_d       = row_q + 3'd1;
                  font_addr_d = {char_q, row_q + 3'd1};
                  state_d     = S_ROM_REQ;
               end
            end else begin
               col_d      = col_q + 3'd1;
               fb_we_d    = cand_we;
               fb_x_d     = cand_px[X_WIDTH-1:0];
               fb_y_d     = cand_py[Y_WIDTH-1:0];
               fb_pixel_d = cand_bit;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         char_q        <= '0;
         x_q           <= '0;
         y_q           <= '0;
         row_q         <= 3'd0;
         col_q         <= 3'd0;
         bits_q        <= 8'd0;
         pop_q         <= 1'b0;
         font_addr_q   <= '0;
         fb_we_q       <= 1'b0;
         fb_x_q        <= '0;
         fb_y_q        <= '0;
         fb_pixel_q    <= 1'b0;
         busy_q        <= 1'b0;
         char_done_q   <= 1'b0;
         chars_drawn_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         char_q        <= char_d;
         x_q           <= x_d;
         y_q           <= y_d;
         row_q         <= row_d;
         col_q         <= col_d;
         bits_q        <= bits_d;
         pop_q         <= pop_d;
         font_addr_q   <= font_addr_d;
         fb_we_q       <= fb_we_d;
         fb_x_q        <= fb_x_d;
         fb_y_q        <= fb_y_d;
         fb_pixel_q    <= fb_pixel_d;
         busy_q        <= busy_d;
         char_done_q   <= char_done_d;
         chars_drawn_q <= chars_drawn_d;
      end
   end

   assign bus.pop         = pop_q;
   assign bus.font_addr   = font_addr_q;
   assign bus.fb_we       = fb_we_q;
   assign bus.fb_x        = fb_x_q;
   assign bus.fb_y        = fb_y_q;
   assign bus.fb_pixel    = fb_pixel_q;
   assign bus.busy        = busy_q;
   assign bus.char_done   = char_done_q;
   assign bus.chars_drawn = chars_drawn_q;

endmodule
